// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants, field-bundle type and helpers.
package rv_pkg;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_SW      = 3'b010;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_S = 2'd2,
    FMT_B = 2'd3
  } fmt_e;

  // One decoded micro-op as held in the first pipeline stage.
  typedef struct packed {
    fmt_e        fmt;
    logic [2:0]  funct3;
    logic        alt;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rd;
    logic [31:0] imm;
  } bundle_t;

  // Immediate-format shifts carry shamt in imm[4:0] and alt in bit 30.
  function automatic logic is_shift(fmt_e fmt, logic [2:0] funct3);
    return (fmt == FMT_I) && ((funct3 == F3_SLL) || (funct3 == F3_SRL_SRA));
  endfunction

endpackage

// File: rtl/rv_encoder_if.sv
// Field-bundle input and encoded-word output channels of rv_encoder.
interface rv_encoder_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_fmt;
  logic [2:0]        in_funct3;
  logic              in_alt;
  logic [4:0]        in_ra;
  logic [4:0]        in_rb;
  logic [4:0]        in_rd;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              err;
  logic [ADDR_W-1:0] count;

  // Encoder side.
  modport slave (
    input  in_valid, in_fmt, in_funct3, in_alt, in_ra, in_rb, in_rd, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_addr, err, count
  );

  // Producer/sink side.
  modport master (
    output in_valid, in_fmt, in_funct3, in_alt, in_ra, in_rb, in_rd, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err, count
  );
endinterface

// File: rtl/rv_imm_pack.sv
// Places the immediate into its format-specific instruction bit positions
// and flags immediates that do not fit the field.
module rv_imm_pack
  import rv_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic [31:0] imm_bits_c,
  output logic        viol_c
);

  logic fits12_c;
  logic fits13_c;

  // Sign-extension checks: upper bits all equal to the field's sign bit.
  always_comb begin
    fits12_c = (&imm[31:11]) || (~|imm[31:11]);
    fits13_c = (&imm[31:12]) || (~|imm[31:12]);
  end

  // Scatter immediate bits and evaluate the range rule per format.
  always_comb begin
    imm_bits_c = '0;
    viol_c     = 1'b0;
    case (fmt)
      FMT_I: begin
        if (is_shift(fmt, funct3)) begin
          imm_bits_c[24:20] = imm[4:0];
          viol_c            = |imm[31:5];
        end else begin
          imm_bits_c[31:20] = imm[11:0];
          viol_c            = !fits12_c;
        end
      end
      FMT_S: begin
        imm_bits_c[31:25] = imm[11:5];
        imm_bits_c[11:7]  = imm[4:0];
        viol_c            = !fits12_c;
      end
      FMT_B: begin
        imm_bits_c[31]    = imm[12];
        imm_bits_c[30:25] = imm[10:5];
        imm_bits_c[11:8]  = imm[4:1];
        imm_bits_c[7]     = imm[11];
        viol_c            = !fits13_c || imm[0];
      end
      default: begin
        imm_bits_c = '0;
        viol_c     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rv_encoder.sv
// Two-stage RV32I R/I/S/B instruction encoder with valid/ready on both sides.
// Optional macro RV_ENC_RANGE_CHECK_EN drops out-of-range immediates and
// raises a sticky err; without it immediates are truncated to their fields.
module rv_encoder
  import rv_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic          clk,
  input logic          rst,
  rv_encoder_if.slave  bus
);

  logic              s1_v_q,  s1_v_d;
  bundle_t           s1_q,    s1_d;
  logic              s2_v_q,  s2_v_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              err_q,   err_d;

  logic        in_ready_c;
  logic        accept_c;
  logic        advance_c;
  logic        out_hs_c;
  logic        drop_c;
  logic        viol_c;
  logic [31:0] imm_bits_c;
  logic [31:0] enc_c;
  bundle_t     in_bundle_c;

  rv_imm_pack u_imm_pack (
    .fmt        (s1_q.fmt),
    .funct3     (s1_q.funct3),
    .imm        (s1_q.imm),
    .imm_bits_c (imm_bits_c),
    .viol_c     (viol_c)
  );

`ifdef RV_ENC_RANGE_CHECK_EN
  // Out-of-range bundles are consumed at the S1->S2 boundary.
  always_comb drop_c = viol_c;
`else
  logic unused_viol;
  // Range flag is ignored; every bundle is forwarded with truncated fields.
  always_comb begin
    drop_c      = 1'b0;
    unused_viol = viol_c;
  end
`endif

  // Handshake qualifiers for both channels.
  always_comb begin
    in_ready_c = !rst && (!s1_v_q || !s2_v_q || bus.out_ready);
    accept_c   = bus.in_valid && in_ready_c;
    advance_c  = s1_v_q && (!s2_v_q || bus.out_ready);
    out_hs_c   = s2_v_q && bus.out_ready;
  end

  // Gather input fields into the stage-1 payload.
  always_comb begin
    in_bundle_c        = '0;
    in_bundle_c.fmt    = fmt_e'(bus.in_fmt);
    in_bundle_c.funct3 = bus.in_funct3;
    in_bundle_c.alt    = bus.in_alt;
    in_bundle_c.ra     = bus.in_ra;
    in_bundle_c.rb     = bus.in_rb;
    in_bundle_c.rd     = bus.in_rd;
    in_bundle_c.imm    = bus.in_imm;
  end

  // Assemble the 32-bit word from the stage-1 bundle.
  always_comb begin
    enc_c = imm_bits_c;
    case (s1_q.fmt)
      FMT_R: enc_c = {1'b0, s1_q.alt, 5'b0, s1_q.rb, s1_q.ra, s1_q.funct3, s1_q.rd, OP_R};
      FMT_I: begin
        enc_c     = imm_bits_c | {12'b0, s1_q.ra, s1_q.funct3, s1_q.rd, OP_I};
        enc_c[30] = is_shift(s1_q.fmt, s1_q.funct3) ? s1_q.alt : imm_bits_c[30];
      end
      FMT_S: enc_c = imm_bits_c | {7'b0, s1_q.rb, s1_q.ra, s1_q.funct3, 5'b0, OP_S};
      FMT_B: enc_c = imm_bits_c | {7'b0, s1_q.rb, s1_q.ra, s1_q.funct3, 5'b0, OP_B};
      default: enc_c = imm_bits_c;
    endcase
  end

  // Next-state for both stages, address/count and sticky error.
  always_comb begin
    s1_v_d  = s1_v_q;
    s1_d    = s1_q;
    s2_v_d  = s2_v_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;

    if (out_hs_c) begin
      s2_v_d  = 1'b0;
      addr_d  = addr_q + ADDR_W'(4);
      count_d = count_q + ADDR_W'(1);
    end

    if (advance_c) begin
      s1_v_d = 1'b0;
      if (drop_c) begin
        err_d = 1'b1;
      end else begin
        s2_v_d  = 1'b1;
        instr_d = enc_c;
      end
    end

    if (accept_c) begin
      s1_v_d = 1'b1;
      s1_d   = in_bundle_c;
    end
  end

  // Pipeline and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q  <= 1'b0;
      s1_q    <= '0;
      s2_v_q  <= 1'b0;
      instr_q <= '0;
      addr_q  <= BASE_ADDR;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      s1_v_q  <= s1_v_d;
      s1_q    <= s1_d;
      s2_v_q  <= s2_v_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = s2_v_q;
  assign bus.out_instr = instr_q;
  assign bus.out_addr  = addr_q;
  assign bus.err       = err_q;
  assign bus.count     = count_q;

endmodule
